if_id_flush_reg: RTL and testbench

- IF/ID pipeline register; consumes the flush signal raised on a taken branch.
- Replaces wrong-path fetched instructions with bubbles for a configurable number of fetch-advance cycles.
- Honours decode stalls and counts flush events for debug.
- Sits between the fetch stage (PC/instruction memory) and the decode stage.

---
 rtl/if_id_flush_reg_if.sv | 40 ++++
 rtl/if_id_flush_reg.sv | 110 +++++++++++
 tb/tb_if_id_flush_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_id_flush_reg_if.sv
// IF/ID boundary bundle between the fetch stage and the decode stage.
//
// Signals:
//   flush       - taken branch resolved; squash wrong-path instructions
//   stall       - decode hazard stall; hold register contents
//   pc_in       - PC of the instruction coming from fetch
//   instr_in    - fetched instruction
//   pc_out      - registered PC presented to decode
//   instr_out   - registered instruction presented to decode
//   valid_out   - 1 = instr_out is a real instruction, 0 = bubble
//   squashing   - high while the register is squashing wrong-path fetches
//   flush_count - saturating count of cycles with flush asserted
//
// Modports:
//   master - the fetch/control side that drives flush, stall, pc_in, instr_in
//   slave  - the IF/ID register itself
interface if_id_flush_reg_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    logic               flush;
    logic               stall;
    logic [PC_W-1:0]    pc_in;
    logic [INSTR_W-1:0] instr_in;
    logic [PC_W-1:0]    pc_out;
    logic [INSTR_W-1:0] instr_out;
    logic               valid_out;
    logic               squashing;
    logic [15:0]        flush_count;

    modport master (
        output flush, stall, pc_in, instr_in,
        input  pc_out, instr_out, valid_out, squashing, flush_count
    );

    modport slave (
        input  flush, stall, pc_in, instr_in,
        output pc_out, instr_out, valid_out, squashing, flush_count
    );
endinterface

// File: rtl/if_id_flush_reg.sv
// IF/ID pipeline register with branch-flush squashing.
//
// On a taken-branch flush the register loads a bubble (NOP_INSTR, valid=0)
// and then keeps loading bubbles for SQUASH_CYCLES fetch-advance cycles in
// total, so the wrong-path instructions already in flight never reach decode.
// Decode stalls freeze the register (and the squash countdown); a flush always
// wins over a stall because the stalled instruction is itself wrong-path.
//
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - if_id_flush_reg_if.slave (flush/stall/pc_in/instr_in in,
//           pc_out/instr_out/valid_out/squashing/flush_count out)
module if_id_flush_reg #(
    parameter int                  PC_W          = 64,
    parameter int                  INSTR_W       = 32,
    parameter int                  SQUASH_CYCLES = 2,
    parameter logic [INSTR_W-1:0]  NOP_INSTR     = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset,
    if_id_flush_reg_if.slave   bus
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    // The flush cycle itself is the first squashed cycle, so the countdown
    // only has to cover the remaining SQUASH_CYCLES-1 fetch advances.
    localparam logic [3:0] SQUASH_RELOAD = 4'(SQUASH_CYCLES - 1);
    localparam bit         MULTI_SQUASH  = (SQUASH_CYCLES > 1);

    state_t             state_reg;
    logic [3:0]         cnt_reg;
    logic [PC_W-1:0]    pc_reg;
    logic [INSTR_W-1:0] instr_reg;
    logic               valid_reg;
    logic               squashing_reg;
    logic [15:0]        flush_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            cnt_reg         <= 4'd0;
            pc_reg          <= '0;
            instr_reg       <= NOP_INSTR;
            valid_reg       <= 1'b0;
            squashing_reg   <= 1'b0;
            flush_count_reg <= 16'd0;
        end else begin
            // Debug counter: saturates rather than wrapping.
            if (bus.flush && (flush_count_reg != 16'hFFFF)) begin
                flush_count_reg <= flush_count_reg + 16'd1;
            end

            unique case (state_reg)
                RUN: begin
                    if (bus.flush) begin
                        pc_reg    <= bus.pc_in;
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                        if (MULTI_SQUASH) begin
                            state_reg     <= SQUASH;
                            squashing_reg <= 1'b1;
                            cnt_reg       <= SQUASH_RELOAD;
                        end
                    end else if (!bus.stall) begin
                        pc_reg    <= bus.pc_in;
                        instr_reg <= bus.instr_in;
                        valid_reg <= 1'b1;
                    end
                end

                SQUASH: begin
                    if (bus.flush) begin
                        // Retrigger: a new branch restarts the full window.
                        pc_reg    <= bus.pc_in;
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                        cnt_reg   <= SQUASH_RELOAD;
                    end else if (!bus.stall) begin
                        pc_reg    <= bus.pc_in;
                        instr_reg <= NOP_INSTR;
                        valid_reg <= 1'b0;
                        cnt_reg   <= cnt_reg - 4'd1;
                        // Counter reaching 0 on this advance ends the window.
                        if (cnt_reg <= 4'd1) begin
                            state_reg     <= RUN;
                            squashing_reg <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_reg     <= RUN;
                    squashing_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_out      = pc_reg;
    assign bus.instr_out   = instr_reg;
    assign bus.valid_out   = valid_reg;
    assign bus.squashing   = squashing_reg;
    assign bus.flush_count = flush_count_reg;

endmodule

// File: tb/tb_if_id_flush_reg.sv
module tb_if_id_flush_reg;

    localparam int          PC_W    = 64;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] NOP     = 32'h00000013;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic               sq;
        logic [15:0]        fc;
        bit                 quiet;
        string              name;
    } exp_t;

    logic clk;
    logic reset;

    if_id_flush_reg_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    if_id_flush_reg #(
        .PC_W          (PC_W),
        .INSTR_W       (INSTR_W),
        .SQUASH_CYCLES (2),
        .NOP_INSTR     (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t exp_q[$];
    int   checks;
    int   passed;
    bit   stim_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the response expected after the
    // following rising edge.
    task automatic step(input bit rst, input bit fl, input bit st,
                        input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                        input logic [PC_W-1:0] e_pc, input logic [INSTR_W-1:0] e_ins,
                        input bit e_v, input bit e_sq, input logic [15:0] e_fc,
                        input string name, input bit quiet = 1'b0);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        bus.flush    = fl;
        bus.stall    = st;
        bus.pc_in    = pc;
        bus.instr_in = ins;
        e.pc    = e_pc;
        e.instr = e_ins;
        e.valid = e_v;
        e.sq    = e_sq;
        e.fc    = e_fc;
        e.quiet = quiet;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the register presents a new output; compare it
    // against the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.pc_out === e.pc && bus.instr_out === e.instr &&
                    bus.valid_out === e.valid && bus.squashing === e.sq &&
                    bus.flush_count === e.fc) begin
                    passed++;
                    if (!e.quiet)
                        $display("ok   %s: pc=%0h instr=%08h valid=%0b squashing=%0b flush_count=%04h",
                                 e.name, bus.pc_out, bus.instr_out, bus.valid_out,
                                 bus.squashing, bus.flush_count);
                end else begin
                    $display("FAIL %s: got pc=%0h instr=%08h valid=%0b squashing=%0b flush_count=%04h, expected pc=%0h instr=%08h valid=%0b squashing=%0b flush_count=%04h",
                             e.name, bus.pc_out, bus.instr_out, bus.valid_out,
                             bus.squashing, bus.flush_count,
                             e.pc, e.instr, e.valid, e.sq, e.fc);
                end
            end
        end
    end

    initial begin
        logic [15:0] efc;
        int          wait_cycles;
        checks       = 0;
        passed       = 0;
        stim_done    = 1'b0;
        reset        = 1'b1;
        bus.flush    = 1'b1;
        bus.stall    = 1'b0;
        bus.pc_in    = 64'h40;
        bus.instr_in = 32'h0;

        // Reset held two cycles with flush asserted: reset must dominate.
        step(1,1,0, 64'h40, 32'hFF, 64'h0, NOP, 0,0, 16'd0, "reset0");
        step(1,1,0, 64'h40, 32'hFF, 64'h0, NOP, 0,0, 16'd0, "reset1");

        // Normal flow, 1-cycle latency.
        step(0,0,0, 64'h00, 32'hA1, 64'h00, 32'hA1, 1,0, 16'd0, "run_a1");
        step(0,0,0, 64'h04, 32'hA2, 64'h04, 32'hA2, 1,0, 16'd0, "run_a2");
        step(0,0,0, 64'h08, 32'hA3, 64'h08, 32'hA3, 1,0, 16'd0, "run_a3");

        // Single flush: two bubbles, one squashing cycle.
        step(0,1,0, 64'h10, 32'hC0, 64'h10, NOP,    0,1, 16'd1, "flush_bubble");
        step(0,0,0, 64'h14, 32'hC1, 64'h14, NOP,    0,0, 16'd1, "squash_bubble");
        step(0,0,0, 64'h18, 32'hC2, 64'h18, 32'hC2, 1,0, 16'd1, "post_squash");

        // Stall during squash freezes the countdown.
        step(0,1,0, 64'h1C, 32'hC3, 64'h1C, NOP,    0,1, 16'd2, "flush2");
        step(0,0,1, 64'h20, 32'hC4, 64'h1C, NOP,    0,1, 16'd2, "sq_stall1");
        step(0,0,1, 64'h20, 32'hC4, 64'h1C, NOP,    0,1, 16'd2, "sq_stall2");
        step(0,0,1, 64'h20, 32'hC4, 64'h1C, NOP,    0,1, 16'd2, "sq_stall3");
        step(0,0,0, 64'h20, 32'hC4, 64'h20, NOP,    0,0, 16'd2, "sq_release");
        step(0,0,0, 64'h24, 32'hC5, 64'h24, 32'hC5, 1,0, 16'd2, "run_after_stall");

        // Flush and stall together in RUN: bubble loaded, not held.
        step(0,0,0, 64'h20, 32'hB0, 64'h20, 32'hB0, 1,0, 16'd2, "load_b0");
        step(0,0,1, 64'h28, 32'hB1, 64'h20, 32'hB0, 1,0, 16'd2, "run_stall_hold");
        step(0,1,1, 64'h28, 32'hB1, 64'h28, NOP,    0,1, 16'd3, "flush_over_stall");
        step(0,0,0, 64'h2C, 32'hB2, 64'h2C, NOP,    0,0, 16'd3, "fs_squash");
        step(0,0,0, 64'h30, 32'hB3, 64'h30, 32'hB3, 1,0, 16'd3, "fs_resume");

        // Retrigger inside SQUASH restarts the window.
        step(0,1,0, 64'h34, 32'hD0, 64'h34, NOP,    0,1, 16'd4, "retrig_a");
        step(0,1,0, 64'h38, 32'hD1, 64'h38, NOP,    0,1, 16'd5, "retrig_b");
        step(0,0,0, 64'h3C, 32'hD2, 64'h3C, NOP,    0,0, 16'd5, "retrig_tail");
        step(0,0,0, 64'h40, 32'hD3, 64'h40, 32'hD3, 1,0, 16'd5, "retrig_resume");

        // Reset asserted mid-squash leaves no residual squash.
        step(0,1,0, 64'h50, 32'hE0, 64'h50, NOP,    0,1, 16'd6, "pre_reset_flush");
        step(1,0,0, 64'h54, 32'hE1, 64'h00, NOP,    0,0, 16'd0, "mid_sq_reset");
        step(0,0,0, 64'h58, 32'hE2, 64'h58, 32'hE2, 1,0, 16'd0, "post_reset_run");

        // Saturation: continuous flush, counter sticks at 0xFFFF.
        for (int i = 0; i < 65540; i++) begin
            efc = (i + 1 >= 65535) ? 16'hFFFF : 16'(i + 1);
            step(0,1,0, 64'(i) * 64'd4, 32'h5A5A0000 | 32'(i & 16'hFFFF),
                 64'(i) * 64'd4, NOP, 0,1, efc, "sat_flush",
                 !((i % 16384) == 0 || i >= 65532));
        end
        step(0,0,0, 64'h100, 32'hF0, 64'h100, NOP,    0,0, 16'hFFFF, "sat_tail");
        step(0,0,0, 64'h104, 32'hF1, 64'h104, 32'hF1, 1,0, 16'hFFFF, "sat_resume");
        stim_done = 1'b1;

        // Drain the scoreboard with a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations outstanding, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
